ad9914_spi_sequencer: RTL and testbench

//  Serial-port controller for the AD9914 DDS. On a load request it snapshots the latched DRG

---
 rtl/ad9914_spi_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_ad9914_spi_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9914_spi_sequencer.sv
// ---------------------------------------------------------------------------
// ad9914_spi_sequencer
//
// Serial-port controller for the AD9914 DDS. A load request snapshots the
// DRG settings and writes them as five 40-bit SPI frames
// ({addr[7:0], data[31:0]}, MSB first), then pulses IO_UPDATE. A sweep request
// restarts the digital ramp by holding DRCTL low and then raising it.
//
// Optional feature macro: AD9914_READBACK_EN
//   defined   : after IO_UPDATE the five registers are read back
//               ({8'h80|addr, 32 clocks}) and compared against the snapshot;
//               any difference sets the sticky verify_err flag.
//   undefined : no read frames, sdo ignored, verify_err tied to 0.
//
// Ports
//   clk, rst                  system clock, synchronous active-low reset
//   load_req, sweep_req       1-cycle request pulses (latched as pending)
//   profile_sel               selects FTW limit pair 1 or 2 at snapshot
//   ftw_lower_1/2, ftw_upper_1/2, sweep_step, sweep_rate   DRG settings
//   sdo                       AD9914 serial data out (readback only)
//   sclk, sdio, cs_n          SPI pins (sclk idles low, cs_n active low)
//   io_update, drctl          AD9914 control pins
//   busy                      high whenever the sequencer is not idle
//   done                      1-cycle pulse at the end of a load sequence
//   verify_err                sticky readback mismatch flag
// ---------------------------------------------------------------------------
module ad9914_spi_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8,
    parameter int IOUP_W  = 4,
    parameter int DRHOLD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        sweep_req,
    input  logic        profile_sel,
    input  logic [31:0] ftw_lower_1,
    input  logic [31:0] ftw_upper_1,
    input  logic [31:0] ftw_lower_2,
    input  logic [31:0] ftw_upper_2,
    input  logic [31:0] sweep_step,
    input  logic [15:0] sweep_rate,
    input  logic        sdo,
    output logic        sclk,
    output logic        sdio,
    output logic        cs_n,
    output logic        io_update,
    output logic        drctl,
    output logic        busy,
    output logic        done,
    output logic        verify_err
);

`ifdef AD9914_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    localparam int         NFRAMES = 5;
    // 80 SCLK half-periods per frame, plus one trailing half-period with
    // cs_n still low after the last falling edge.
    localparam logic [6:0] HP_TAIL = 7'd80;

    typedef enum logic [2:0] {
        S_IDLE, S_SNAP, S_SHIFT, S_GAP, S_IOUPD, S_SWEEP
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic [6:0]  hp_reg;
    logic [2:0]  frame_reg;
    logic        rd_reg;
    logic [39:0] sh_reg;
    logic [31:0] shadow_reg [0:NFRAMES-1];
    logic [31:0] snap_data  [0:NFRAMES-1];
    logic [7:0]  frame_addr [0:NFRAMES-1];
    logic [39:0] frame_word [0:NFRAMES-1];
    logic [39:0] rd_word    [0:NFRAMES-1];
    logic        load_pend_reg, sweep_pend_reg, cfg_valid_reg, drctl_reg;
    logic        verify_err_reg;

    logic div_end, shift_done, last_frame, gap_end, ioup_end, sweep_end;
    logic seq_done, load_any, sweep_any;

    // Frame payloads in write order: lower, upper, step, step, {rate,rate}.
    assign snap_data[0] = profile_sel ? ftw_lower_2 : ftw_lower_1;
    assign snap_data[1] = profile_sel ? ftw_upper_2 : ftw_upper_1;
    assign snap_data[2] = sweep_step;
    assign snap_data[3] = sweep_step;
    assign snap_data[4] = {sweep_rate, sweep_rate};

    genvar gi;
    generate
        for (gi = 0; gi < NFRAMES; gi++) begin : g_frame
            assign frame_addr[gi] = 8'(4 + gi);
            assign frame_word[gi] = {frame_addr[gi], shadow_reg[gi]};
            assign rd_word[gi]    = {frame_addr[gi] | 8'h80, 32'h0};
        end
    endgenerate

    assign load_any   = load_req | load_pend_reg;
    assign sweep_any  = sweep_req | sweep_pend_reg;
    assign div_end    = (cnt_reg == 8'(CLK_DIV - 1));
    assign shift_done = (state_reg == S_SHIFT) && (hp_reg == HP_TAIL) && div_end;
    assign last_frame = (frame_reg == 3'(NFRAMES - 1));
    assign gap_end    = (state_reg == S_GAP)   && (cnt_reg == 8'(CS_GAP - 1));
    assign ioup_end   = (state_reg == S_IOUPD) && (cnt_reg == 8'(IOUP_W - 1));
    assign sweep_end  = (state_reg == S_SWEEP) && (cnt_reg == 8'(DRHOLD - 1));
    assign seq_done   = READBACK ? (shift_done && rd_reg && last_frame) : ioup_end;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (load_any)                        state_next = S_SNAP;
                else if (sweep_any && cfg_valid_reg) state_next = S_SWEEP;
            end
            S_SNAP:  state_next = S_SHIFT;
            S_SHIFT: begin
                if (shift_done) begin
                    if (!last_frame) state_next = S_GAP;
                    else if (rd_reg) state_next = S_IDLE;
                    else             state_next = S_IOUPD;
                end
            end
            S_GAP:   if (gap_end)   state_next = S_SHIFT;
            S_IOUPD: if (ioup_end)  state_next = READBACK ? S_GAP : S_IDLE;
            S_SWEEP: if (sweep_end) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        sclk       = (state_reg == S_SHIFT) && hp_reg[0];
        sdio       = (state_reg == S_SHIFT) && sh_reg[39];
        cs_n       = (state_reg != S_SHIFT);
        io_update  = (state_reg == S_IOUPD);
        busy       = (state_reg != S_IDLE);
        done       = seq_done;
        drctl      = drctl_reg;
        verify_err = verify_err_reg;
    end

    // Datapath: timing counters, shifter, snapshot, request flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg        <= '0;
            hp_reg         <= '0;
            frame_reg      <= '0;
            rd_reg         <= 1'b0;
            sh_reg         <= '0;
            load_pend_reg  <= 1'b0;
            sweep_pend_reg <= 1'b0;
            cfg_valid_reg  <= 1'b0;
            drctl_reg      <= 1'b0;
            for (int i = 0; i < NFRAMES; i++) shadow_reg[i] <= '0;
        end else begin
            // A request in the SNAP cycle itself is kept for a later pass.
            load_pend_reg <= (state_reg == S_SNAP) ? load_req : (load_pend_reg | load_req);
            // IDLE consumes a sweep either by running it or by discarding it
            // when no configuration has been written yet.
            if (state_reg == S_IDLE && !load_any && sweep_any)
                sweep_pend_reg <= 1'b0;
            else
                sweep_pend_reg <= sweep_pend_reg | sweep_req;

            if (state_next != state_reg || (state_reg == S_SHIFT && div_end))
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 8'd1;

            if (state_reg != S_SHIFT) hp_reg <= '0;
            else if (div_end)         hp_reg <= hp_reg + 7'd1;

            if (state_reg == S_IDLE || ioup_end)  frame_reg <= '0;
            else if (shift_done && !last_frame)   frame_reg <= frame_reg + 3'd1;

            if (state_reg == S_IDLE)        rd_reg <= 1'b0;
            else if (ioup_end && READBACK)  rd_reg <= 1'b1;

            // The first frame comes straight from the inputs because the
            // shadow registers are only being written on this same edge.
            if (state_reg == S_SNAP)
                sh_reg <= {frame_addr[0], snap_data[0]};
            else if (gap_end)
                sh_reg <= rd_reg ? rd_word[frame_reg] : frame_word[frame_reg];
            else if (state_reg == S_SHIFT && div_end && hp_reg[0])
                sh_reg <= {sh_reg[38:0], 1'b0};

            if (state_reg == S_SNAP)
                for (int i = 0; i < NFRAMES; i++) shadow_reg[i] <= snap_data[i];

            if (seq_done) cfg_valid_reg <= 1'b1;

            if (state_reg == S_IDLE && state_next == S_SWEEP) drctl_reg <= 1'b0;
            else if (sweep_end)                               drctl_reg <= 1'b1;
        end
    end

`ifdef AD9914_READBACK_EN
    logic [31:0] rd_data_reg;

    // sdo is captured on the SCLK rising edges of the 32 data bits
    // (half-periods 16..78) and checked once the frame has finished.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_reg    <= '0;
            verify_err_reg <= 1'b0;
        end else begin
            if (state_reg == S_SHIFT && rd_reg && div_end && !hp_reg[0] &&
                hp_reg >= 7'd16 && hp_reg < HP_TAIL)
                rd_data_reg <= {rd_data_reg[30:0], sdo};
            if (state_reg == S_SNAP)
                verify_err_reg <= 1'b0;
            else if (shift_done && rd_reg && rd_data_reg != shadow_reg[frame_reg])
                verify_err_reg <= 1'b1;
        end
    end
`else
    logic unused_sdo;
    assign unused_sdo     = sdo;
    assign verify_err_reg = 1'b0;
`endif

endmodule

// File: tb/tb_ad9914_spi_sequencer.sv
`timescale 1ns/1ps
module tb_ad9914_spi_sequencer;
    localparam int CLK_DIV   = 4;
    localparam int IOUP_W    = 4;
    localparam int DRHOLD    = 4;
    localparam int FRAME_LOW = 81 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req = 1'b0, sweep_req = 1'b0, profile_sel = 1'b0;
    logic [31:0] ftw_lower_1 = '0, ftw_upper_1 = '0, ftw_lower_2 = '0, ftw_upper_2 = '0;
    logic [31:0] sweep_step = '0;
    logic [15:0] sweep_rate = '0;
    logic        sdo = 1'b0;
    logic        sclk, sdio, cs_n, io_update, drctl, busy, done, verify_err;

    always #5 clk = ~clk;

    ad9914_spi_sequencer dut (
        .clk(clk), .rst(rst), .load_req(load_req), .sweep_req(sweep_req),
        .profile_sel(profile_sel), .ftw_lower_1(ftw_lower_1), .ftw_upper_1(ftw_upper_1),
        .ftw_lower_2(ftw_lower_2), .ftw_upper_2(ftw_upper_2), .sweep_step(sweep_step),
        .sweep_rate(sweep_rate), .sdo(sdo), .sclk(sclk), .sdio(sdio), .cs_n(cs_n),
        .io_update(io_update), .drctl(drctl), .busy(busy), .done(done), .verify_err(verify_err)
    );

    int n_pass = 0, n_total = 0;

    // ---------------- AD9914 pin-level model ----------------
    logic [39:0] spi_q[$];
    logic [39:0] spi_sh = '0;
    logic [7:0]  spi_addr = '0;
    logic [31:0] dds_mem [0:255];
    logic [31:0] sdo_word;
    int          spi_bits = 0, sdo_falls = 0, rd_frames = 0, bad_len = 0;
    bit          corrupt_upper = 1'b0;

    always @(negedge cs_n) begin
        spi_bits  = 0;
        sdo_falls = 0;
    end

    always @(posedge sclk) begin
        spi_sh = {spi_sh[38:0], sdio};
        spi_bits++;
        if (spi_bits == 8) spi_addr = spi_sh[7:0];
    end

    always @(negedge sclk) begin
        if (cs_n === 1'b0) begin
            sdo_falls++;
            if (sdo_falls >= 8 && sdo_falls < 40 && spi_addr[7]) begin
                sdo_word = dds_mem[spi_addr & 8'h7f];
                if (corrupt_upper && spi_addr == 8'h85) sdo_word = sdo_word ^ 32'h1;
                sdo = sdo_word[39 - sdo_falls];
            end
        end
    end

    always @(posedge cs_n) begin
        if (spi_bits != 0) begin
            if (spi_bits != 40) bad_len++;
            if (!spi_sh[39]) begin
                spi_q.push_back(spi_sh);
                dds_mem[spi_sh[39:32]] = spi_sh[31:0];
            end else begin
                rd_frames++;
            end
        end
        spi_bits = 0;
    end

    // ---------------- cycle-level pulse monitor ----------------
    int  ioup_q[$], csl_q[$], drlow_q[$];
    int  ioup_run = 0, csl_run = 0, sclk_run = 0, drlow_run = 0;
    int  sclk_min = 1000, sclk_max = 0, done_cnt = 0, done_long = 0;
    logic prev_done = 1'b0, prev_drctl = 1'b0;
    time last_done_t = 0, last_rise_t = 0;

    always @(negedge clk) begin
        if (io_update === 1'b1) ioup_run++;
        else if (ioup_run != 0) begin ioup_q.push_back(ioup_run); ioup_run = 0; end
        if (cs_n === 1'b0) csl_run++;
        else if (csl_run != 0) begin csl_q.push_back(csl_run); csl_run = 0; end
        if (sclk === 1'b1) sclk_run++;
        else if (sclk_run != 0) begin
            if (sclk_run < sclk_min) sclk_min = sclk_run;
            if (sclk_run > sclk_max) sclk_max = sclk_run;
            sclk_run = 0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            last_done_t = $time;
            if (prev_done === 1'b1) done_long++;
        end
        prev_done = done;
        if (prev_drctl === 1'b0 && drctl === 1'b1) begin
            drlow_q.push_back(drlow_run);
            drlow_run   = 0;
            last_rise_t = $time;
        end else if (busy === 1'b1 && drctl === 1'b0) drlow_run++;
        else drlow_run = 0;
        prev_drctl = drctl;
    end

    // ---------------- reference model ----------------
    logic [39:0] exp_q[$];

    task automatic model_load(input bit prof, input logic [31:0] l1, u1, l2, u2, st,
                              input logic [15:0] rt);
        exp_q.push_back({8'h04, prof ? l2 : l1});
        exp_q.push_back({8'h05, prof ? u2 : u1});
        exp_q.push_back({8'h06, st});
        exp_q.push_back({8'h07, st});
        exp_q.push_back({8'h08, rt, rt});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input bit prof, input logic [31:0] l1, u1, l2, u2, st,
                           input logic [15:0] rt);
        profile_sel = prof; ftw_lower_1 = l1; ftw_upper_1 = u1;
        ftw_lower_2 = l2; ftw_upper_2 = u2; sweep_step = st; sweep_rate = rt;
    endtask

    task automatic pulse_load();
        load_req = 1'b1; tick(1); load_req = 1'b0;
    endtask

    task automatic pulse_sweep();
        sweep_req = 1'b1; tick(1); sweep_req = 1'b0;
    endtask

    // Waits for busy to stay low for 5 cycles; ok=0 on timeout.
    task automatic wait_quiet(output bit ok);
        int quiet = 0, cyc = 0;
        while (quiet < 5 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b0) quiet++; else quiet = 0;
        end
        ok = (quiet >= 5);
        tick(1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad = 0;
        rst = 1'b0; tick(3); rst = 1'b1;
        @(negedge clk);
        n_total++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs_n); else n_pass++;
        n_total++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else n_pass++;
        n_total++; if (sdio !== 1'b0) $display("FAIL reset_sdio: got %b want 0", sdio); else n_pass++;
        n_total++; if (drctl !== 1'b0) $display("FAIL reset_drctl: got %b want 0", drctl); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (io_update !== 1'b0) $display("FAIL reset_io_update: got %b want 0", io_update); else n_pass++;
        n_total++; if (verify_err !== 1'b0) $display("FAIL reset_verify_err: got %b want 0", verify_err); else n_pass++;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || sclk !== 1'b0 || drctl !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL reset_idle_1000: bad cycles %0d want 0", bad); else n_pass++;
        $display("test_reset: idle check over 1000 cycles, bad=%0d", bad);
        tick(1);
    endtask

    task automatic test_sweep_before_load();
        int base = drlow_q.size();
        int busy_seen = 0;
        pulse_sweep();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy === 1'b1 || drctl !== 1'b0) busy_seen++;
        end
        n_total++; if (drlow_q.size() != base) $display("FAIL sweep_nocfg_rise: got %0d rises want 0", drlow_q.size() - base); else n_pass++;
        n_total++; if (busy_seen != 0) $display("FAIL sweep_nocfg_activity: got %0d cycles want 0", busy_seen); else n_pass++;
        $display("test_sweep_before_load: rises=%0d", drlow_q.size() - base);
        tick(1);
    endtask

    task automatic test_load_directed();
        int fb = spi_q.size(), ib = ioup_q.size(), db = done_cnt, cb = csl_q.size();
        bit ok;
        set_cfg(1'b0, 32'h1111_0000, 32'h2222_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0100, 16'h0010);
        model_load(1'b0, 32'h1111_0000, 32'h2222_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0100, 16'h0010);
        load_req = 1'b1;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL busy_pulse_cycle: got %b want 0", busy); else n_pass++;
        tick(1); load_req = 1'b0;
        @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy); else n_pass++;
        wait_quiet(ok);
        n_total++; if (!ok) $display("FAIL directed_timeout: busy stuck got 1 want 0"); else n_pass++;
        n_total++; if (spi_q.size() - fb != exp_q.size()) $display("FAIL directed_nframes: got %0d want %0d", spi_q.size() - fb, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && fb + i < spi_q.size(); i++) begin
            n_total++;
            if (spi_q[fb + i] !== exp_q[i]) $display("FAIL directed_frame%0d: got %h want %h", i, spi_q[fb + i], exp_q[i]);
            else n_pass++;
            $display("directed frame %0d: %h/%h", i, spi_q[fb + i][39:32], spi_q[fb + i][31:0]);
        end
        exp_q.delete();
        n_total++; if (ioup_q.size() - ib != 1) $display("FAIL directed_ioup_count: got %0d want 1", ioup_q.size() - ib); else n_pass++;
        n_total++; if (ioup_q.size() > ib && ioup_q[ib] != IOUP_W) $display("FAIL directed_ioup_width: got %0d want %0d", ioup_q[ib], IOUP_W); else n_pass++;
        n_total++; if (done_cnt - db != 1) $display("FAIL directed_done_count: got %0d want 1", done_cnt - db); else n_pass++;
        n_total++; if (done_long != 0) $display("FAIL done_width: got %0d long pulses want 0", done_long); else n_pass++;
        n_total++; if (sclk_min != CLK_DIV || sclk_max != CLK_DIV) $display("FAIL sclk_half_period: got %0d..%0d want %0d", sclk_min, sclk_max, CLK_DIV); else n_pass++;
        n_total++; if (bad_len != 0) $display("FAIL frame_bits: got %0d bad frames want 0", bad_len); else n_pass++;
        for (int i = cb; i < csl_q.size(); i++) begin
            n_total++;
            if (csl_q[i] != FRAME_LOW) $display("FAIL cs_low_len%0d: got %0d want %0d", i - cb, csl_q[i], FRAME_LOW);
            else n_pass++;
        end
    endtask

    task automatic test_sweep_after_done();
        int base = drlow_q.size();
        bit ok;
        pulse_sweep();
        wait_quiet(ok);
        n_total++; if (!ok) $display("FAIL sweep_timeout: busy stuck got 1 want 0"); else n_pass++;
        n_total++; if (drlow_q.size() - base != 1) $display("FAIL sweep_rises: got %0d want 1", drlow_q.size() - base); else n_pass++;
        n_total++; if (drlow_q.size() > base && drlow_q[base] != DRHOLD) $display("FAIL sweep_low_len: got %0d want %0d", drlow_q[base], DRHOLD); else n_pass++;
        n_total++; if (drctl !== 1'b1) $display("FAIL sweep_drctl_final: got %b want 1", drctl); else n_pass++;
        $display("test_sweep_after_done: rises=%0d drctl=%b", drlow_q.size() - base, drctl);
    endtask

    task automatic test_load_and_sweep();
        int fb = spi_q.size(), db = done_cnt, rb = drlow_q.size();
        bit ok;
        set_cfg(1'b1, 32'h0, 32'h0, 32'h3333_4444, 32'h5555_6666, 32'h0000_0777, 16'h0ABC);
        model_load(1'b1, 32'h0, 32'h0, 32'h3333_4444, 32'h5555_6666, 32'h0000_0777, 16'h0ABC);
        load_req = 1'b1; sweep_req = 1'b1; tick(1); load_req = 1'b0; sweep_req = 1'b0;
        wait_quiet(ok);
        n_total++; if (!ok) $display("FAIL both_timeout: busy stuck got 1 want 0"); else n_pass++;
        n_total++; if (spi_q.size() - fb != exp_q.size()) $display("FAIL both_nframes: got %0d want %0d", spi_q.size() - fb, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && fb + i < spi_q.size(); i++) begin
            n_total++;
            if (spi_q[fb + i] !== exp_q[i]) $display("FAIL both_frame%0d: got %h want %h", i, spi_q[fb + i], exp_q[i]);
            else n_pass++;
        end
        exp_q.delete();
        n_total++; if (done_cnt - db != 1) $display("FAIL both_done: got %0d want 1", done_cnt - db); else n_pass++;
        n_total++; if (drlow_q.size() - rb != 1) $display("FAIL both_rises: got %0d want 1", drlow_q.size() - rb); else n_pass++;
        n_total++; if (drlow_q.size() > rb && drlow_q[rb] != DRHOLD) $display("FAIL both_low_len: got %0d want %0d", drlow_q[rb], DRHOLD); else n_pass++;
        n_total++; if (last_rise_t <= last_done_t) $display("FAIL both_order: rise at %0t want after done at %0t", last_rise_t, last_done_t); else n_pass++;
        $display("test_load_and_sweep: frames=%0d rises=%0d", spi_q.size() - fb, drlow_q.size() - rb);
    endtask

    task automatic test_mid_frame_reload();
        int fb = spi_q.size(), db = done_cnt, ib = ioup_q.size(), cyc = 0;
        bit ok;
        set_cfg(1'b0, 32'hA000_0001, 32'hA000_0002, 32'h0, 32'h0, 32'h0000_0010, 16'h0020);
        model_load(1'b0, 32'hA000_0001, 32'hA000_0002, 32'h0, 32'h0, 32'h0000_0010, 16'h0020);
        pulse_load();
        while (!(spi_q.size() - fb == 2 && cs_n === 1'b0) && cyc < 5000) begin
            @(negedge clk); cyc++;
        end
        n_total++; if (cyc >= 5000) $display("FAIL mid_wait_frame3: got timeout want frame 3 start"); else n_pass++;
        tick(1);
        set_cfg(1'b0, 32'hB000_0001, 32'hB000_0002, 32'h0, 32'h0, 32'h0000_0010, 16'h0020);
        model_load(1'b0, 32'hB000_0001, 32'hB000_0002, 32'h0, 32'h0, 32'h0000_0010, 16'h0020);
        pulse_load();
        wait_quiet(ok);
        n_total++; if (!ok) $display("FAIL mid_timeout: busy stuck got 1 want 0"); else n_pass++;
        n_total++; if (spi_q.size() - fb != exp_q.size()) $display("FAIL mid_nframes: got %0d want %0d", spi_q.size() - fb, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && fb + i < spi_q.size(); i++) begin
            n_total++;
            if (spi_q[fb + i] !== exp_q[i]) $display("FAIL mid_frame%0d: got %h want %h", i, spi_q[fb + i], exp_q[i]);
            else n_pass++;
        end
        exp_q.delete();
        n_total++; if (done_cnt - db != 2) $display("FAIL mid_done: got %0d want 2", done_cnt - db); else n_pass++;
        n_total++; if (ioup_q.size() - ib != 2) $display("FAIL mid_ioup: got %0d want 2", ioup_q.size() - ib); else n_pass++;
        $display("test_mid_frame_reload: frames=%0d dones=%0d", spi_q.size() - fb, done_cnt - db);
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 4; it++) begin
            int fb = spi_q.size(), db = done_cnt;
            bit ok, prof;
            logic [31:0] l1, u1, l2, u2, st;
            logic [15:0] rt;
            prof = 1'($urandom_range(0, 1));
            l1 = $urandom; u1 = $urandom; l2 = $urandom; u2 = $urandom; st = $urandom;
            rt = 16'($urandom);
            set_cfg(prof, l1, u1, l2, u2, st, rt);
            model_load(prof, l1, u1, l2, u2, st, rt);
            pulse_load();
            tick(1);
            // Scramble inputs after the snapshot; the frames must not change.
            set_cfg(~prof, $urandom, $urandom, $urandom, $urandom, $urandom, 16'($urandom));
            wait_quiet(ok);
            n_total++; if (!ok) $display("FAIL rand%0d_timeout: busy stuck got 1 want 0", it); else n_pass++;
            n_total++; if (spi_q.size() - fb != exp_q.size()) $display("FAIL rand%0d_nframes: got %0d want %0d", it, spi_q.size() - fb, exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size() && fb + i < spi_q.size(); i++) begin
                n_total++;
                if (spi_q[fb + i] !== exp_q[i]) $display("FAIL rand%0d_frame%0d: got %h want %h", it, i, spi_q[fb + i], exp_q[i]);
                else n_pass++;
            end
            exp_q.delete();
            n_total++; if (done_cnt - db != 1) $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt - db); else n_pass++;
            n_total++; if (verify_err !== 1'b0) $display("FAIL rand%0d_verify_err: got %b want 0", it, verify_err); else n_pass++;
            $display("test_random_loads: iter %0d prof=%0d lower=%h upper=%h", it, prof, prof ? l2 : l1, prof ? u2 : u1);
        end
    endtask

`ifdef AD9914_READBACK_EN
    task automatic test_readback();
        int rb = rd_frames;
        bit ok;
        corrupt_upper = 1'b1;
        set_cfg(1'b0, 32'h1111_0000, 32'h2222_0000, 32'h0, 32'h0, 32'h0000_0100, 16'h0010);
        pulse_load();
        wait_quiet(ok);
        n_total++; if (!ok) $display("FAIL rb_timeout: busy stuck got 1 want 0"); else n_pass++;
        n_total++; if (rd_frames - rb != 5) $display("FAIL rb_read_frames: got %0d want 5", rd_frames - rb); else n_pass++;
        n_total++; if (verify_err !== 1'b1) $display("FAIL rb_detect: got %b want 1", verify_err); else n_pass++;
        corrupt_upper = 1'b0;
        pulse_load();
        tick(3);
        n_total++; if (verify_err !== 1'b0) $display("FAIL rb_clear_at_snap: got %b want 0", verify_err); else n_pass++;
        wait_quiet(ok);
        n_total++; if (verify_err !== 1'b0) $display("FAIL rb_stay_clear: got %b want 0", verify_err); else n_pass++;
        $display("test_readback: read frames=%0d verify_err=%b", rd_frames - rb, verify_err);
    endtask
`endif

    initial begin
        test_reset();
        test_sweep_before_load();
        test_load_directed();
        test_sweep_after_done();
        test_load_and_sweep();
        test_mid_frame_reload();
        test_random_loads();
`ifdef AD9914_READBACK_EN
        test_readback();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
